// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run/step/halt controller: states, command
// opcodes, stop causes and the halt instruction word.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_DONE = 2'b11
   } run_state_t;

   typedef enum logic [1:0] {
      OP_RUN     = 2'b00,
      OP_STEP    = 2'b01,
      OP_HALT    = 2'b10,
      OP_CLR_CNT = 2'b11
   } cmd_op_t;

   typedef enum logic [2:0] {
      CAUSE_NONE       = 3'd0,
      CAUSE_HALT_CMD   = 3'd1,
      CAUSE_STEP_DONE  = 3'd2,
      CAUSE_BREAKPOINT = 3'd3,
      CAUSE_EBREAK     = 3'd4
   } stop_cause_t;

   // ebreak encoding, used by benches to build programs that halt
   localparam logic [31:0] HALT_INSN = 32'h0010_0073;

endpackage

// File: rtl/wrap_counter.sv
// Free-running wrap-around counter with an increment enable and a
// synchronous clear that takes priority over the increment.
module wrap_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + {{(W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller: gates the CPU's global_en from host commands and
// stops precisely on ebreak, breakpoint or step completion.
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd_op,
   input  logic [STEP_W-1:0] cmd_arg,
   input  logic              bp_en,
   input  logic [31:0]       bp_pc,
   input  logic              commit,
   input  logic [31:0]       commit_pc,
   input  logic              commit_halt,
   output logic              global_en,
   output logic [1:0]        state,
   output logic [2:0]        stop_cause,
   output logic              stop_pulse,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  inst_cnt
);

   localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

   run_state_t        cur_state;
   run_state_t        state_nxt;
   logic [STEP_W-1:0] step_left;
   logic [STEP_W-1:0] left_nxt;
   stop_cause_t       cause_q;
   stop_cause_t       cause_nxt;
   logic              pulse_nxt;
   logic              en_d;
   logic              commit_new;
   logic              stop_now;
   stop_cause_t       stop_code;
   logic              active;
   logic              clr_cnt;
   cmd_op_t           op;

   assign op         = cmd_op_t'(cmd_op);
   assign active     = (cur_state == ST_RUN) || (cur_state == ST_STEP);
   // commit outputs freeze with the pipeline, so only a commit following an enabled cycle is new
   assign commit_new = commit & en_d;
   assign clr_cnt    = cmd_valid && (op == OP_CLR_CNT);

   assign state      = cur_state;
   assign stop_cause = cause_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state  <= ST_IDLE;
         step_left  <= '0;
         cause_q    <= CAUSE_NONE;
         stop_pulse <= 1'b0;
         en_d       <= 1'b0;
      end else begin
         cur_state  <= state_nxt;
         step_left  <= left_nxt;
         cause_q    <= cause_nxt;
         stop_pulse <= pulse_nxt;
         en_d       <= global_en;
      end
   end

   always_comb begin
      state_nxt = cur_state;
      left_nxt  = step_left;
      cause_nxt = cause_q;
      pulse_nxt = 1'b0;
      case (cur_state)
         ST_IDLE: begin
            if (cmd_valid && (op == OP_RUN)) begin
               state_nxt = ST_RUN;
               cause_nxt = CAUSE_NONE;
            end else if (cmd_valid && (op == OP_STEP)) begin
               state_nxt = ST_STEP;
               left_nxt  = (cmd_arg == '0) ? STEP_ONE : cmd_arg;
               cause_nxt = CAUSE_NONE;
            end
         end
         ST_RUN, ST_STEP: begin
            if (stop_now) begin
               state_nxt = (stop_code == CAUSE_EBREAK) ? ST_DONE : ST_IDLE;
               cause_nxt = stop_code;
               pulse_nxt = 1'b1;
            end else if (cmd_valid && (op == OP_HALT)) begin
               state_nxt = ST_IDLE;
               cause_nxt = CAUSE_HALT_CMD;
               pulse_nxt = 1'b1;
            end else if ((cur_state == ST_STEP) && commit_new) begin
               left_nxt = step_left - STEP_ONE;
            end
         end
         default: begin
         end
      endcase
   end

   // Stop decision is combinational so the pipeline freezes in the very cycle the stopping commit shows
   always_comb begin
      stop_now  = 1'b0;
      stop_code = CAUSE_NONE;
      if (active && commit_new) begin
         if (commit_halt) begin
            stop_now  = 1'b1;
            stop_code = CAUSE_EBREAK;
         end else if (bp_en && (commit_pc == bp_pc)) begin
            stop_now  = 1'b1;
            stop_code = CAUSE_BREAKPOINT;
         end else if ((cur_state == ST_STEP) && (step_left == STEP_ONE)) begin
            stop_now  = 1'b1;
            stop_code = CAUSE_STEP_DONE;
         end
      end
      global_en = active & ~stop_now;
   end

   wrap_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (global_en),
      .clr   (clr_cnt),
      .count (cycle_cnt)
   );

   wrap_counter #(.W(CNT_W)) u_inst_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (commit_new),
      .clr   (clr_cnt),
      .count (inst_cnt)
   );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a simple CPU model feeds commits with random bubbles
// and a cycle-level reference of the control rules checks every output.
module tb_cpu_run_ctrl;

   localparam int CNT_W  = 4;
   localparam int STEP_W = 16;
   localparam int MOD    = 1 << CNT_W;

   logic              clk;
   logic              rst;
   logic              cmd_valid;
   logic [1:0]        cmd_op;
   logic [STEP_W-1:0] cmd_arg;
   logic              bp_en;
   logic [31:0]       bp_pc;
   logic              commit;
   logic [31:0]       commit_pc;
   logic              commit_halt;
   logic              global_en;
   logic [1:0]        state;
   logic [2:0]        stop_cause;
   logic              stop_pulse;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [CNT_W-1:0]  inst_cnt;

   int total = 0;
   int bad   = 0;

   // CPU model: program counter, loop bounds and the PC holding ebreak
   logic [31:0] cpu_pc, loop_lo, loop_hi, halt_pc;
   int          bubble_pct;

   // Reference model: 0 idle, 1 run, 2 step, 3 done
   int m_state, m_left, m_cause, exp_cyc, exp_inst, pulses_seen;
   bit m_pulse, newc, en_exp;

   cpu_run_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_op      (cmd_op),
      .cmd_arg     (cmd_arg),
      .bp_en       (bp_en),
      .bp_pc       (bp_pc),
      .commit      (commit),
      .commit_pc   (commit_pc),
      .commit_halt (commit_halt),
      .global_en   (global_en),
      .state       (state),
      .stop_cause  (stop_cause),
      .stop_pulse  (stop_pulse),
      .cycle_cnt   (cycle_cnt),
      .inst_cnt    (inst_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] op, input int arg);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = STEP_W'(arg);
   endtask

   task automatic reset_model();
      m_state  = 0;
      m_left   = 0;
      m_cause  = 0;
      m_pulse  = 1'b0;
      newc     = 1'b0;
      en_exp   = 1'b0;
      exp_cyc  = 0;
      exp_inst = 0;
   endtask

   task automatic cpu_advance();
      if ($urandom_range(99) < bubble_pct) begin
         commit      = 1'b0;
         commit_halt = 1'b0;
      end else begin
         commit      = 1'b1;
         commit_pc   = cpu_pc;
         commit_halt = (cpu_pc == halt_pc);
         cpu_pc      = (cpu_pc == loop_hi) ? loop_lo : cpu_pc + 32'd4;
      end
   endtask

   // One clock cycle: judge the stop rules mid-cycle, then step model and CPU past the edge
   task automatic tick();
      int stop_c, ns, nl, nc;
      bit np, clr, running;
      @(negedge clk);
      running = (m_state == 1) || (m_state == 2);
      stop_c  = 0;
      if (running && newc) begin
         if (commit_halt)                            stop_c = 4;
         else if (bp_en && (commit_pc == bp_pc))     stop_c = 3;
         else if ((m_state == 2) && (m_left == 1))   stop_c = 2;
      end
      en_exp = running && (stop_c == 0);
      check_output("global_en", 32'(global_en), 32'(en_exp));
      ns = m_state; nl = m_left; nc = m_cause; np = 1'b0;
      if (stop_c != 0) begin
         ns = (stop_c == 4) ? 3 : 0;
         nc = stop_c;
         np = 1'b1;
      end else if (running && cmd_valid && (cmd_op == 2'b10)) begin
         ns = 0; nc = 1; np = 1'b1;
      end else if ((m_state == 0) && cmd_valid && (cmd_op == 2'b00)) begin
         ns = 1; nc = 0;
      end else if ((m_state == 0) && cmd_valid && (cmd_op == 2'b01)) begin
         ns = 2; nc = 0;
         nl = (cmd_arg == 0) ? 1 : int'(cmd_arg);
      end else if ((m_state == 2) && newc) begin
         nl = m_left - 1;
      end
      clr = cmd_valid && (cmd_op == 2'b11);
      @(posedge clk);
      #1;
      exp_cyc  = clr ? 0 : (exp_cyc + (en_exp ? 1 : 0)) % MOD;
      exp_inst = clr ? 0 : (exp_inst + (newc ? 1 : 0)) % MOD;
      m_state = ns; m_left = nl; m_cause = nc; m_pulse = np;
      if (en_exp) begin
         cpu_advance();
         newc = commit;
      end else begin
         newc = 1'b0;
      end
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_arg   = '0;
      if (stop_pulse === 1'b1) pulses_seen++;
      check_output("state", 32'(state), 32'(m_state));
      check_output("stop_cause", 32'(stop_cause), 32'(m_cause));
      check_output("stop_pulse", 32'(stop_pulse), 32'(m_pulse));
      check_output("cycle_cnt", 32'(cycle_cnt), 32'(exp_cyc));
      check_output("inst_cnt", 32'(inst_cnt), 32'(exp_inst));
   endtask

   task automatic run_until_stop(input int bound);
      int n = 0;
      while (((m_state == 1) || (m_state == 2)) && (n < bound)) begin
         tick();
         n++;
      end
      check_output("stop_timeout", 32'((m_state == 1) || (m_state == 2)), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      reset_model();
   endtask

   task automatic use_loop_program();
      cpu_pc  = 32'h0;
      loop_lo = 32'h0;
      loop_hi = 32'h1C;
      halt_pc = 32'hFFFF_FFFF;
   endtask

   initial begin
      int base, arg, n;
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0;
      bp_en = 1'b0; bp_pc = 32'h0;
      commit = 1'b0; commit_pc = 32'h0; commit_halt = 1'b0;
      cpu_pc = 32'h0; loop_lo = 32'h0; loop_hi = 32'hFFFF_FFF0; halt_pc = 32'h28;
      bubble_pct  = 25;
      pulses_seen = 0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_state", 32'(state), 32'd0);
      check_output("reset_global_en", 32'(global_en), 32'd0);
      check_output("reset_cause", 32'(stop_cause), 32'd0);
      check_output("reset_pulse", 32'(stop_pulse), 32'd0);
      check_output("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
      check_output("reset_inst_cnt", 32'(inst_cnt), 32'd0);
      rst = 1'b0;

      $display("[TB] straight-line program ending in ebreak");
      apply_stimulus(2'b00, 0);
      tick();
      run_until_stop(400);
      check_output("ebreak_state", 32'(state), 32'd3);
      check_output("ebreak_cause", 32'(stop_cause), 32'd4);
      check_output("ebreak_inst_cnt", 32'(inst_cnt), 32'd11);
      apply_stimulus(2'b10, 0);
      tick();
      apply_stimulus(2'b00, 0);
      repeat (4) tick();
      check_output("ebreak_pulses", 32'(pulses_seen), 32'd1);
      check_output("done_sticky", 32'(state), 32'd3);

      $display("[TB] single-step");
      do_reset();
      use_loop_program();
      base = exp_inst;
      apply_stimulus(2'b01, 3);
      tick();
      run_until_stop(200);
      check_output("step3_retired", 32'(inst_cnt), 32'((base + 3) % MOD));
      check_output("step3_cause", 32'(stop_cause), 32'd2);
      base = exp_inst;
      apply_stimulus(2'b01, 0);
      tick();
      run_until_stop(200);
      check_output("step0_retired", 32'(inst_cnt), 32'((base + 1) % MOD));
      for (int i = 0; i < 4; i++) begin
         arg  = $urandom_range(1, 6);
         base = exp_inst;
         apply_stimulus(2'b01, arg);
         tick();
         apply_stimulus(2'b00, 0);
         tick();
         run_until_stop(200);
         check_output("stepN_retired", 32'(inst_cnt), 32'((base + arg) % MOD));
      end

      $display("[TB] breakpoint on loop");
      bp_en = 1'b1;
      bp_pc = 32'h10;
      apply_stimulus(2'b00, 0);
      tick();
      run_until_stop(300);
      check_output("bp_cause", 32'(stop_cause), 32'd3);
      check_output("bp_pc_hit", commit_pc, 32'h10);
      base = exp_inst;
      apply_stimulus(2'b00, 0);
      tick();
      run_until_stop(300);
      check_output("bp_resume_cause", 32'(stop_cause), 32'd3);
      check_output("bp_resume_retired", 32'(inst_cnt), 32'((base + 8) % MOD));

      $display("[TB] halt command and frozen commit");
      bp_en = 1'b0;
      apply_stimulus(2'b00, 0);
      tick();
      repeat ($urandom_range(3, 8)) tick();
      apply_stimulus(2'b10, 0);
      tick();
      run_until_stop(10);
      check_output("halt_cause", 32'(stop_cause), 32'd1);
      tick();
      base = exp_inst;
      repeat (5) tick();
      check_output("frozen_inst_cnt", 32'(inst_cnt), 32'(base));

      bp_en = 1'b1;
      apply_stimulus(2'b00, 0);
      tick();
      n = 0;
      while ((m_state == 1) && (n < 300)) begin
         if (newc && (commit_pc == bp_pc)) apply_stimulus(2'b10, 0);
         tick();
         n++;
      end
      check_output("halt_bp_cause", 32'(stop_cause), 32'd3);
      bp_en = 1'b0;

      $display("[TB] counter clear and wrap");
      apply_stimulus(2'b00, 0);
      tick();
      repeat (3) tick();
      apply_stimulus(2'b11, 0);
      tick();
      check_output("clr_cycle_cnt", 32'(cycle_cnt), 32'd0);
      check_output("clr_inst_cnt", 32'(inst_cnt), 32'd0);
      apply_stimulus(2'b10, 0);
      tick();
      run_until_stop(10);
      repeat (2) tick();
      apply_stimulus(2'b11, 0);
      tick();
      apply_stimulus(2'b00, 0);
      tick();
      repeat (16) tick();
      check_output("cycle_wrap", 32'(cycle_cnt), 32'd0);
      apply_stimulus(2'b10, 0);
      tick();
      run_until_stop(10);

      $display("[TB] reset during step");
      apply_stimulus(2'b01, 12);
      tick();
      repeat (3) tick();
      #3;
      rst = 1'b1;
      #1;
      check_output("async_global_en", 32'(global_en), 32'd0);
      check_output("async_state", 32'(state), 32'd0);
      check_output("async_cause", 32'(stop_cause), 32'd0);
      check_output("async_pulse", 32'(stop_pulse), 32'd0);
      check_output("async_cycle_cnt", 32'(cycle_cnt), 32'd0);
      check_output("async_inst_cnt", 32'(inst_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      reset_model();
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
